mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory-access stage and MEM/WB pipeline register of the 5-stage pipelined CPU. It takes the EX/MEM bundle, performs the data-memory load or store, and registers everything the write-back stage consumes: MemtoReg, Of, Jal, RegWr, Dout, Result, Rw and PC. It owns the data memory array and the pipeline stall and flush behaviour for this boundary.

Parameters:
MEM_DEPTH_LOG2, 10, log2 of data-memory depth in 32-bit words (1024 words)
RESET_PC, 32'h0000_0000, value loaded into PC output on reset/flush

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
stall  input  1  hold MEM/WB register, suppress memory write
flush  input  1  insert bubble into MEM/WB register
ex_valid  input  1  EX/MEM slot holds a real instruction
ex_MemWr  input  1  store instruction
ex_MemtoReg  input  1  load instruction (write-back selects Dout)
ex_RegWr  input  1  register write request
ex_Of  input  1  ALU overflow flag
ex_Jal  input  1  jal instruction
ex_MemOp  input  3  access size/sign (see Behaviour)
ex_Result  input  32  ALU result / byte address
ex_BusB  input  32  store data
ex_Rw  input  5  destination register
ex_PC  input  32  instruction PC
MemtoReg  output  1  registered
Of  output  1  registered
Jal  output  1  registered
RegWr  output  1  registered; forced 0 on misaligned load
Dout  output  32  registered, extended load data
Result  output  32  registered ALU result
Rw  output  5  registered
PC  output  32  registered
wb_valid  output  1  registered valid
misalign  output  1  registered; 1 for the instruction that faulted

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0 except PC=RESET_PC; memory contents not reset; reset overrides stall and flush.
- Priority: reset > flush > stall > normal load.
- Word index = ex_Result[MEM_DEPTH_LOG2+1:2]; upper address bits ignored (wrap-around, no fault).
- ex_MemOp: 000 word; 001 byte signed; 010 byte unsigned; 011 half signed; 100 half unsigned; 101-111 treated as word.
- Misaligned: word with ex_Result[1:0]!=0, half with ex_Result[0]!=0. Misaligned store is suppressed. Misaligned load registers RegWr=0. In both cases misalign=1.
- Store: memory write at the clk edge when ex_valid & ex_MemWr & ~stall & ~flush & ~ex_Of & ~misaligned. Byte/half stores update only the addressed lanes (little-endian; byte lane = ex_Result[1:0], half lane = ex_Result[1]).
- Load: asynchronous read of the addressed word, lane-selected and extended, captured into Dout at the edge. Latency is 1 cycle from EX/MEM to WB.
- Load-after-store: a load in cycle N+1 to an address stored in cycle N returns the new data.
- Non-load instructions: Dout = 0.
- Normal edge (no stall/flush): every output takes its ex_ counterpart. Control bits are ANDed with ex_valid, so an invalid slot produces RegWr=MemtoReg=Jal=Of=0.
- stall=1: all outputs hold; no memory write.
- flush=1: outputs become the bubble: all outputs 0, PC=RESET_PC, wb_valid=0; no memory write.
- Simultaneous stall and flush: flush wins.
- Reset mid-store: no write occurs at that edge.

Optional Feature:
MEM_BYTE_ACCESS_EN
- Defined: full byte/halfword support as above.
- Undefined: ex_MemOp is ignored and every access is a word access. Only [1:0]!=0 causes misalign. All stores write the full 32-bit word.

Test Plan:
1. Store word 0x1234_5678 to addr 0x10, then load word from 0x10 next cycle -> Dout=0x1234_5678, MemtoReg=1, RegWr=1 one cycle after the load.
2. After test 1: store byte 0xAB to 0x11, load byte signed from 0x11 -> Dout=0xFFFF_FFAB; load byte unsigned -> 0x0000_00AB; load word from 0x10 -> 0x1234_AB78.
3. Load word from addr 0x12 -> misalign=1, RegWr=0. Store word to 0x12 -> misalign=1 and memory at 0x10 unchanged.
4. Load at 0x20 with stall=1 for 3 cycles -> outputs unchanged and no write. With stall and flush high together -> wb_valid=0, RegWr=0, PC=RESET_PC.
5. Store with ex_Of=1 -> memory unchanged and Of=1. A jal at PC=0x40 with ex_Jal=1 -> Jal=1, PC=0x40, Rw propagated.
6. Drive rst_n=0 during a store to 0x30 -> all outputs 0 and memory at 0x30 keeps its old value. With MEM_BYTE_ACCESS_EN undefined, a byte store to 0x10 writes the full word.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access stage with data memory and MEM/WB pipeline register.
// Optional feature macro MEM_BYTE_ACCESS_EN enables byte/halfword accesses; without it every access is a word.
module mem_access_stage #(
    parameter int unsigned MEM_DEPTH_LOG2 = 10,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic        ex_MemWr,
    input  logic        ex_MemtoReg,
    input  logic        ex_RegWr,
    input  logic        ex_Of,
    input  logic        ex_Jal,
    input  logic [2:0]  ex_MemOp,
    input  logic [31:0] ex_Result,
    input  logic [31:0] ex_BusB,
    input  logic [4:0]  ex_Rw,
    input  logic [31:0] ex_PC,
    output logic        MemtoReg,
    output logic        Of,
    output logic        Jal,
    output logic        RegWr,
    output logic [31:0] Dout,
    output logic [31:0] Result,
    output logic [4:0]  Rw,
    output logic [31:0] PC,
    output logic        wb_valid,
    output logic        misalign
);

    localparam int unsigned DEPTH = 1 << MEM_DEPTH_LOG2;

    typedef struct packed {
        logic        memtoreg;
        logic        of;
        logic        jal;
        logic        regwr;
        logic [31:0] dout;
        logic [31:0] result;
        logic [4:0]  rw;
        logic [31:0] pc;
        logic        valid;
        logic        misalign;
    } wb_t;

    logic [31:0]               mem_q [DEPTH];
    logic [MEM_DEPTH_LOG2-1:0] word_idx;
    logic [31:0]               rdata;
    logic                      is_byte;
    logic                      is_half;
    logic                      addr_bad;
    logic                      misaligned;
    logic                      is_load;
    logic                      mem_we;
    logic [3:0]                be;
    logic [31:0]               wdata;
    logic [7:0]                lane_b;
    logic [15:0]               lane_h;
    logic [31:0]               load_data;
    wb_t                       bubble;
    wb_t                       wb_d;
    wb_t                       wb_q;

    assign word_idx = ex_Result[MEM_DEPTH_LOG2+1:2];
    assign rdata    = mem_q[word_idx];

`ifdef MEM_BYTE_ACCESS_EN
    assign is_byte = (ex_MemOp == 3'b001) || (ex_MemOp == 3'b010);
    assign is_half = (ex_MemOp == 3'b011) || (ex_MemOp == 3'b100);
`else
    logic unused_memop;
    assign unused_memop = ^ex_MemOp;
    assign is_byte      = 1'b0;
    assign is_half      = 1'b0;
`endif

    assign addr_bad   = is_byte ? 1'b0 : (is_half ? ex_Result[0] : (ex_Result[1:0] != 2'b00));
    assign misaligned = ex_valid & (ex_MemWr | ex_MemtoReg) & addr_bad;
    assign is_load    = ex_valid & ex_MemtoReg;
    assign mem_we     = rst_n & ex_valid & ex_MemWr & ~stall & ~flush & ~ex_Of & ~misaligned;

    // Store data is replicated across lanes so the byte enables alone pick the target lane.
    always_comb begin
        be    = '1;
        wdata = ex_BusB;
        if (is_byte) begin
            be                 = '0;
            be[ex_Result[1:0]] = 1'b1;
            wdata              = {4{ex_BusB[7:0]}};
        end else if (is_half) begin
            be    = ex_Result[1] ? 4'b1100 : 4'b0011;
            wdata = {2{ex_BusB[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        case (ex_Result[1:0])
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h    = ex_Result[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
`ifdef MEM_BYTE_ACCESS_EN
        case (ex_MemOp)
            3'b001:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b010:  load_data = {24'h0, lane_b};
            3'b011:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_data = {16'h0, lane_h};
            default: load_data = rdata;
        endcase
`endif
    end

    always_comb begin
        bubble    = '0;
        bubble.pc = RESET_PC;
    end

    always_comb begin
        wb_d = wb_q;
        if (flush) begin
            wb_d = bubble;
        end else if (!stall) begin
            wb_d.memtoreg = is_load;
            wb_d.of       = ex_valid & ex_Of;
            wb_d.jal      = ex_valid & ex_Jal;
            wb_d.regwr    = ex_valid & ex_RegWr & ~(is_load & addr_bad);
            wb_d.dout     = is_load ? load_data : '0;
            wb_d.result   = ex_Result;
            wb_d.rw       = ex_Rw;
            wb_d.pc       = ex_PC;
            wb_d.valid    = ex_valid;
            wb_d.misalign = misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_q <= bubble;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign MemtoReg = wb_q.memtoreg;
    assign Of       = wb_q.of;
    assign Jal      = wb_q.jal;
    assign RegWr    = wb_q.regwr;
    assign Dout     = wb_q.dout;
    assign Result   = wb_q.result;
    assign Rw       = wb_q.rw;
    assign PC       = wb_q.pc;
    assign wb_valid = wb_q.valid;
    assign misalign = wb_q.misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: reference model feeds a scoreboard queue, outputs checked one cycle later.
// Byte/half scenarios follow MEM_BYTE_ACCESS_EN the same way the design does.
module tb_mem_access_stage;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

    typedef struct packed {
        logic        memtoreg;
        logic        of;
        logic        jal;
        logic        regwr;
        logic [31:0] dout;
        logic [31:0] result;
        logic [4:0]  rw;
        logic [31:0] pc;
        logic        valid;
        logic        misalign;
    } wb_t;

    typedef struct packed {
        logic        rst_n;
        logic        stall;
        logic        flush;
        logic        valid;
        logic        memwr;
        logic        memtoreg;
        logic        regwr;
        logic        of;
        logic        jal;
        logic [2:0]  memop;
        logic [31:0] addr;
        logic [31:0] busb;
        logic [4:0]  rw;
        logic [31:0] pc;
    } in_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_MemWr = 1'b0;
    logic        ex_MemtoReg = 1'b0;
    logic        ex_RegWr = 1'b0;
    logic        ex_Of = 1'b0;
    logic        ex_Jal = 1'b0;
    logic [2:0]  ex_MemOp = '0;
    logic [31:0] ex_Result = '0;
    logic [31:0] ex_BusB = '0;
    logic [4:0]  ex_Rw = '0;
    logic [31:0] ex_PC = '0;
    logic        MemtoReg;
    logic        Of;
    logic        Jal;
    logic        RegWr;
    logic [31:0] Dout;
    logic [31:0] Result;
    logic [4:0]  Rw;
    logic [31:0] PC;
    logic        wb_valid;
    logic        misalign;

    int unsigned checks = 0;
    int unsigned errors = 0;
    wb_t         exp_q [$];
    wb_t         prev;
    logic [31:0] mem_m [int unsigned];

    mem_access_stage #(.MEM_DEPTH_LOG2(10), .RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg),
        .ex_RegWr(ex_RegWr), .ex_Of(ex_Of), .ex_Jal(ex_Jal), .ex_MemOp(ex_MemOp),
        .ex_Result(ex_Result), .ex_BusB(ex_BusB), .ex_Rw(ex_Rw), .ex_PC(ex_PC),
        .MemtoReg(MemtoReg), .Of(Of), .Jal(Jal), .RegWr(RegWr), .Dout(Dout),
        .Result(Result), .Rw(Rw), .PC(PC), .wb_valid(wb_valid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic wb_t model(input in_t t);
        wb_t         e;
        logic        byte_a;
        logic        half_a;
        logic        bad;
        logic        mis;
        logic        ld;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int unsigned idx;
        e    = '0;
        e.pc = TB_RESET_PC;
        if (t.rst_n && !t.flush) begin
            if (t.stall) begin
                e = prev;
            end else begin
                byte_a = 1'b0;
                half_a = 1'b0;
`ifdef MEM_BYTE_ACCESS_EN
                byte_a = (t.memop == 3'd1) || (t.memop == 3'd2);
                half_a = (t.memop == 3'd3) || (t.memop == 3'd4);
`endif
                bad = byte_a ? 1'b0 : (half_a ? t.addr[0] : (t.addr[1:0] != 2'b00));
                mis = t.valid && (t.memwr || t.memtoreg) && bad;
                ld  = t.valid && t.memtoreg;
                idx = 32'(t.addr[11:2]);
                w   = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
                b   = 8'(w >> (8 * 32'(t.addr[1:0])));
                h   = t.addr[1] ? w[31:16] : w[15:0];
                e.memtoreg = ld;
                e.of       = t.valid && t.of;
                e.jal      = t.valid && t.jal;
                e.regwr    = t.valid && t.regwr && !(ld && bad);
                e.dout     = 32'h0;
                if (ld) begin
                    if (byte_a) e.dout = (t.memop == 3'd1) ? {{24{b[7]}}, b} : {24'h0, b};
                    else if (half_a) e.dout = (t.memop == 3'd3) ? {{16{h[15]}}, h} : {16'h0, h};
                    else e.dout = w;
                end
                e.result   = t.addr;
                e.rw       = t.rw;
                e.pc       = t.pc;
                e.valid    = t.valid;
                e.misalign = mis;
                if (t.valid && t.memwr && !t.of && !mis) begin
                    if (byte_a) w[8*t.addr[1:0] +: 8] = t.busb[7:0];
                    else if (half_a) w[16*t.addr[1] +: 16] = t.busb[15:0];
                    else w = t.busb;
                    mem_m[idx] = w;
                end
            end
        end
        prev = e;
        return e;
    endfunction

    function automatic wb_t sample();
        wb_t s;
        s.memtoreg = MemtoReg; s.of = Of; s.jal = Jal; s.regwr = RegWr;
        s.dout = Dout; s.result = Result; s.rw = Rw; s.pc = PC;
        s.valid = wb_valid; s.misalign = misalign;
        return s;
    endfunction

    function automatic in_t mk_nop();
        in_t t;
        t       = '0;
        t.rst_n = 1'b1;
        return t;
    endfunction

    function automatic in_t mk_st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
        in_t t;
        t = mk_nop();
        t.valid = 1'b1; t.memwr = 1'b1; t.memop = op; t.addr = a; t.busb = d;
        t.pc = 32'h0000_2000 + a;
        return t;
    endfunction

    function automatic in_t mk_ld(input logic [31:0] a, input logic [2:0] op, input logic [4:0] r);
        in_t t;
        t = mk_nop();
        t.valid = 1'b1; t.memtoreg = 1'b1; t.regwr = 1'b1; t.memop = op; t.addr = a; t.rw = r;
        t.pc = 32'h0000_3000 + a;
        return t;
    endfunction

    task automatic step(input in_t t);
        @(negedge clk);
        rst_n = t.rst_n; stall = t.stall; flush = t.flush;
        ex_valid = t.valid; ex_MemWr = t.memwr; ex_MemtoReg = t.memtoreg;
        ex_RegWr = t.regwr; ex_Of = t.of; ex_Jal = t.jal; ex_MemOp = t.memop;
        ex_Result = t.addr; ex_BusB = t.busb; ex_Rw = t.rw; ex_PC = t.pc;
        exp_q.push_back(model(t));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_t t;
        wb_t e;
        wb_t s;
        t = mk_st(32'h10, 32'hFFFF_FFFF, 3'd0);
        t.rst_n = 1'b0;
        t.flush = 1'b1;
        t.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(t);
            e = exp_q.pop_front();
            s = sample();
            checks++;
            if (s !== e) begin
                errors++;
                $display("FAIL reset got=%h exp=%h", s, e);
            end
        end
        checks++;
        if (s.pc !== TB_RESET_PC || s.valid !== 1'b0 || s.regwr !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc got=%h exp=%h", s.pc, TB_RESET_PC);
        end
    endtask

    task automatic test_word();
        in_t list [3];
        wb_t e;
        wb_t s;
        list[0] = mk_st(32'h10, 32'h1234_5678, 3'd0);
        list[1] = mk_ld(32'h10, 3'd0, 5'd3);
        list[2] = mk_ld(32'h8000_0010, 3'd0, 5'd4);
        foreach (list[i]) begin
            step(list[i]);
            e = exp_q.pop_front();
            s = sample();
            checks++;
            if (s !== e) begin
                errors++;
                $display("FAIL word_%0d got=%h exp=%h", i, s, e);
            end
            if (i > 0) begin
                checks++;
                if (s.dout !== 32'h1234_5678 || s.memtoreg !== 1'b1 || s.regwr !== 1'b1) begin
                    errors++;
                    $display("FAIL word_load_const_%0d got=%h exp=12345678", i, s.dout);
                end
            end
        end
    endtask

    task automatic test_byte();
        in_t list [$];
        wb_t e;
        wb_t s;
`ifdef MEM_BYTE_ACCESS_EN
        logic [31:0] want [6];
        list.push_back(mk_st(32'h11, 32'h0000_00AB, 3'd1));
        list.push_back(mk_ld(32'h11, 3'd1, 5'd5));
        list.push_back(mk_ld(32'h11, 3'd2, 5'd5));
        list.push_back(mk_ld(32'h10, 3'd0, 5'd5));
        list.push_back(mk_ld(32'h12, 3'd3, 5'd6));
        list.push_back(mk_ld(32'h12, 3'd4, 5'd6));
        want = '{32'h0, 32'hFFFF_FFAB, 32'h0000_00AB, 32'h1234_AB78, 32'h0000_1234, 32'h0000_1234};
`else
        logic [31:0] want [3];
        list.push_back(mk_st(32'h11, 32'h0000_00AB, 3'd1));
        list.push_back(mk_ld(32'h10, 3'd1, 5'd5));
        list.push_back(mk_st(32'h10, 32'hCAFE_F00D, 3'd1));
        want = '{32'h0, 32'h1234_5678, 32'h0};
`endif
        foreach (list[i]) begin
            step(list[i]);
            e = exp_q.pop_front();
            s = sample();
            checks++;
            if (s !== e) begin
                errors++;
                $display("FAIL byte_%0d got=%h exp=%h", i, s, e);
            end
            checks++;
            if (s.dout !== want[i]) begin
                errors++;
                $display("FAIL byte_const_%0d got=%h exp=%h", i, s.dout, want[i]);
            end
        end
`ifndef MEM_BYTE_ACCESS_EN
        step(mk_ld(32'h10, 3'd0, 5'd7));
        e = exp_q.pop_front();
        s = sample();
        checks++;
        if (s !== e || s.dout !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL word_only_byte_store got=%h exp=cafef00d", s.dout);
        end
        step(mk_st(32'h10, 32'h1234_AB78, 3'd0));
        void'(exp_q.pop_front());
`endif
    endtask

    task automatic test_misalign();
        in_t list [3];
        wb_t e;
        wb_t s;
        list[0] = mk_ld(32'h12, 3'd0, 5'd8);
        list[1] = mk_st(32'h12, 32'hDEAD_BEEF, 3'd0);
        list[2] = mk_ld(32'h10, 3'd0, 5'd8);
        foreach (list[i]) begin
            step(list[i]);
            e = exp_q.pop_front();
            s = sample();
            checks++;
            if (s !== e) begin
                errors++;
                $display("FAIL misalign_%0d got=%h exp=%h", i, s, e);
            end
        end
        checks++;
        if (s.dout !== 32'h1234_AB78) begin
            errors++;
            $display("FAIL misalign_store_suppressed got=%h exp=1234ab78", s.dout);
        end
    endtask

    task automatic test_stall_flush();
        in_t t;
        wb_t e;
        wb_t s;
        wb_t held;
        step(mk_st(32'h20, 32'h55AA_55AA, 3'd0));
        void'(exp_q.pop_front());
        step(mk_ld(32'h20, 3'd0, 5'd9));
        e = exp_q.pop_front();
        held = sample();
        checks++;
        if (held !== e) begin
            errors++;
            $display("FAIL stall_pre got=%h exp=%h", held, e);
        end
        t = mk_st(32'h20, 32'h0BAD_0BAD, 3'd0);
        t.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(t);
            e = exp_q.pop_front();
            s = sample();
            checks++;
            if (s !== e || s !== held) begin
                errors++;
                $display("FAIL stall_hold_%0d got=%h exp=%h", i, s, e);
            end
        end
        step(mk_ld(32'h20, 3'd0, 5'd9));
        e = exp_q.pop_front();
        s = sample();
        checks++;
        if (s !== e || s.dout !== 32'h55AA_55AA) begin
            errors++;
            $display("FAIL stall_no_write got=%h exp=55aa55aa", s.dout);
        end
        t = mk_ld(32'h20, 3'd0, 5'd9);
        t.stall = 1'b1;
        t.flush = 1'b1;
        step(t);
        e = exp_q.pop_front();
        s = sample();
        checks++;
        if (s !== e || s.valid !== 1'b0 || s.regwr !== 1'b0 || s.pc !== TB_RESET_PC) begin
            errors++;
            $display("FAIL stall_flush got=%h exp=%h", s, e);
        end
    endtask

    task automatic test_of_jal();
        in_t t;
        wb_t e;
        wb_t s;
        t = mk_st(32'h10, 32'h7777_7777, 3'd0);
        t.of = 1'b1;
        step(t);
        e = exp_q.pop_front();
        s = sample();
        checks++;
        if (s !== e || s.of !== 1'b1) begin
            errors++;
            $display("FAIL of_store got=%h exp=%h", s, e);
        end
        step(mk_ld(32'h10, 3'd0, 5'd1));
        e = exp_q.pop_front();
        s = sample();
        checks++;
        if (s !== e || s.dout !== 32'h1234_AB78) begin
            errors++;
            $display("FAIL of_no_write got=%h exp=1234ab78", s.dout);
        end
        t = mk_nop();
        t.valid = 1'b1; t.jal = 1'b1; t.regwr = 1'b1; t.rw = 5'd31;
        t.pc = 32'h40; t.addr = 32'h44;
        step(t);
        e = exp_q.pop_front();
        s = sample();
        checks++;
        if (s !== e || s.jal !== 1'b1 || s.pc !== 32'h40 || s.rw !== 5'd31) begin
            errors++;
            $display("FAIL jal got=%h exp=%h", s, e);
        end
        t.valid = 1'b0;
        step(t);
        e = exp_q.pop_front();
        s = sample();
        checks++;
        if (s !== e || s.jal !== 1'b0 || s.regwr !== 1'b0) begin
            errors++;
            $display("FAIL invalid_slot got=%h exp=%h", s, e);
        end
    endtask

    task automatic test_reset_store();
        in_t t;
        wb_t e;
        wb_t s;
        step(mk_st(32'h30, 32'hA5A5_0001, 3'd0));
        void'(exp_q.pop_front());
        t = mk_st(32'h30, 32'h5A5A_0002, 3'd0);
        t.rst_n = 1'b0;
        step(t);
        e = exp_q.pop_front();
        s = sample();
        checks++;
        if (s !== e || s.pc !== TB_RESET_PC || s.result !== 32'h0) begin
            errors++;
            $display("FAIL reset_store got=%h exp=%h", s, e);
        end
        step(mk_ld(32'h30, 3'd0, 5'd2));
        e = exp_q.pop_front();
        s = sample();
        checks++;
        if (s !== e || s.dout !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL reset_no_write got=%h exp=a5a50001", s.dout);
        end
    endtask

    task automatic test_back_to_back();
        in_t t;
        wb_t e;
        wb_t s;
        for (int i = 0; i < 16; i++) begin
            step(mk_st(32'(i * 4), $urandom, 3'd0));
            e = exp_q.pop_front();
        end
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 20);
            case ($urandom_range(0, 2))
                0:       t = mk_st(a, $urandom, 3'($urandom_range(0, 7)));
                1:       t = mk_ld(a, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
                default: begin
                    t = mk_nop();
                    t.valid = 1'b1; t.regwr = 1'b1; t.addr = a; t.rw = 5'd12;
                end
            endcase
            t.pc    = 32'h0000_4000 + 32'(i * 4);
            t.valid = ($urandom_range(0, 7) != 0);
            t.of    = ($urandom_range(0, 9) == 0);
            t.stall = ($urandom_range(0, 7) == 0);
            t.flush = ($urandom_range(0, 9) == 0);
            step(t);
            e = exp_q.pop_front();
            s = sample();
            checks++;
            if (s !== e) begin
                errors++;
                $display("FAIL b2b_%0d got=%h exp=%h", i, s, e);
            end
        end
    endtask

    initial begin
        prev = '0;
        test_reset();
        test_word();
        test_byte();
        test_misalign();
        test_stall_flush();
        test_of_jal();
        test_reset_store();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
